hazard_unit_sb: RTL and testbench
=================================

Name: hazard_unit_sb

Overview:
- Parametrised, stateful successor to the MIPS pipeline hazard unit.
- Provides E-stage and D-stage (branch compare) forwarding selects, and load-use and branch stalls.
- Adds HI/LO multi-cycle mult/div busy tracking, a taken-branch D flush, saturating per-cause stall counters and a sticky stall-watchdog error.
- Sits beside the five-stage datapath; all pipeline control originates here.

Parameters:
REG_W, 5, register-specifier width (register file holds 2**REG_W regs; reg 0 hardwired zero)
MD_LAT, 4, mult/div latency in cycles after issue from E (>=1)
CNT_W, 16, width of each stall performance counter
WD_MAX, 8, max consecutive stall cycles before hang_err sets (> MD_LAT+1)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
rs_d, rt_d  in  REG_W  D-stage source specifiers
rs_e, rt_e  in  REG_W  E-stage source specifiers
writereg_e, writereg_m, writereg_w  in  REG_W  destination specifiers per stage
regwrite_e, regwrite_m, regwrite_w  in  1  stage writes register file
memtoreg_e, memtoreg_m  in  1  stage holds a load
branch_d  in  1  D holds a branch needing register compare
pcsrc_d  in  1  branch in D resolved taken
md_start_e  in  1  mult/div issuing from E this cycle
mfhilo_d  in  1  D holds mfhi/mflo
cnt_clr  in  1  synchronous clear of stall counters
forward_ae, forward_be  out  2  E operand select: 00 regfile, 01 W result, 10 M ALU result
forward_ad, forward_bd  out  1  D compare operand from M
stall_f, stall_d  out  1  hold PC / IF-ID register
flush_d, flush_e  out  1  bubble into IF-ID / ID-EX
md_busy  out  1  HI/LO result pending
stall_cause  out  2  00 none, 01 load, 10 branch, 11 mult/div
lw_cnt, br_cnt, md_cnt  out  CNT_W  saturating stall-cycle counts per cause
hang_err  out  1  sticky watchdog error

Behaviour:
- Match(x,y) = (x != 0) && (x == y). All matches use full REG_W bits.
- forward_ae: 10 if Match(rs_e,writereg_m)&&regwrite_m; else 01 if Match(rs_e,writereg_w)&&regwrite_w; else 00. M has priority over W. forward_be uses rt_e in the same way.
- forward_ad = Match(rs_d,writereg_m) && regwrite_m && branch_d. forward_bd uses rt_d in the same way.
- lwstall = memtoreg_e && (Match(rs_d,writereg_e) || Match(rt_d,writereg_e)).
- brstall = branch_d && ((regwrite_e && (Match(rs_d,writereg_e) || Match(rt_d,writereg_e))) || (memtoreg_m && (Match(rs_d,writereg_m) || Match(rt_d,writereg_m)))).
- mdstall = mfhilo_d && (md_busy || md_start_e).
- stall = lwstall | brstall | mdstall.
- stall_f = stall_d = flush_e = stall. flush_d = pcsrc_d && !stall.
- All of the above outputs are combinational, with zero latency.
- stall_cause priority is load > branch > mult/div. The counter for the reported cause only increments, so exactly one counter moves per stall cycle.
- md counter (width clog2(MD_LAT+1)):
  - reset 0.
  - md_start_e loads MD_LAT, including while busy (restart).
  - otherwise decrements if nonzero.
  - md_busy = counter != 0.
  - mult then mfhi back-to-back gives exactly MD_LAT+1 stall cycles.
- Counters:
  - lw_cnt/br_cnt/md_cnt reset 0.
  - cnt_clr has priority over increment.
  - each counter holds at 2**CNT_W-1 (no wrap).
- Watchdog:
  - run counter resets 0, increments while stall, and clears to 0 when stall deasserts.
  - when run reaches WD_MAX with stall still high, hang_err sets and stays set until reset_n.
  - cnt_clr does not affect hang_err.
  - run saturates at WD_MAX.
- Reset (async, any cycle including mid-stall or mid-mult): md counter, perf counters, run counter and hang_err go to 0 immediately, so md_busy=0. Combinational outputs follow inputs with md_busy=0.

Test Plan:
- Load-use: lw $8 in E (memtoreg_e=1, regwrite_e=1, writereg_e=8), D reads rs_d=8 -> one cycle with stall_f=stall_d=flush_e=1 and stall_cause=01, lw_cnt 0->1; next cycle writereg_m=8, regwrite_m=1, rs_e=8 -> forward_ae=10.
- Branch: beq rs_d=9 with add $9 in E -> one brstall cycle. Next cycle add in M -> forward_ad=1, stall=0. With pcsrc_d=1 -> flush_d=1; with stall also high, flush_d=0.
- Register zero and priority: writereg_m=writereg_w=0 with regwrite -> forward_ae=00. Both M and W match rs_e=5 -> forward_ae=10.
- Mult/div, MD_LAT=4: md_start_e pulse with mfhilo_d held -> stall for 5 cycles, md_cnt=5. Second md_start_e at counter=2 reloads to 4, md_busy stays 1.
- Watchdog and saturation, WD_MAX=8: hold stall 8 cycles -> hang_err=1 and stays set after stall drops and after cnt_clr. CNT_W=2 with 5 stall cycles -> counter=3.
- Async reset asserted mid-mult (counter=3): md_busy=0 immediately without a clock edge, all counters and hang_err read 0.

Source files
------------

// File: rtl/hazard_unit_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_unit_sb : pipeline forwarding/stall control with mult/div tracking,  |
// | per-cause stall counters and a sticky stall watchdog.        Rev 1.0        |
// +----------------------------------------------------------------------------+
module hazard_unit_sb #(
  parameter int REG_W  = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16,
  parameter int WD_MAX = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rt_e,
  input  logic [REG_W-1:0] writereg_e,
  input  logic [REG_W-1:0] writereg_m,
  input  logic [REG_W-1:0] writereg_w,
  input  logic             regwrite_e,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  input  logic             memtoreg_e,
  input  logic             memtoreg_m,
  input  logic             branch_d,
  input  logic             pcsrc_d,
  input  logic             md_start_e,
  input  logic             mfhilo_d,
  input  logic             cnt_clr,
  output logic [1:0]       forward_ae,
  output logic [1:0]       forward_be,
  output logic             forward_ad,
  output logic             forward_bd,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic             md_busy,
  output logic [1:0]       stall_cause,
  output logic [CNT_W-1:0] lw_cnt,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] md_cnt,
  output logic             hang_err
);

  localparam int MD_W  = $clog2(MD_LAT + 1);
  localparam int RUN_W = $clog2(WD_MAX + 1);

  localparam logic [MD_W-1:0]  C_MD_LOAD  = MD_W'(MD_LAT);
  localparam logic [RUN_W-1:0] C_RUN_MAX  = RUN_W'(WD_MAX);
  localparam logic [RUN_W-1:0] C_RUN_LAST = RUN_W'(WD_MAX - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [1:0] C_CAUSE_NONE = 2'b00;
  localparam logic [1:0] C_CAUSE_LOAD = 2'b01;
  localparam logic [1:0] C_CAUSE_BR   = 2'b10;
  localparam logic [1:0] C_CAUSE_MD   = 2'b11;

  localparam logic [1:0] C_FWD_RF = 2'b00;
  localparam logic [1:0] C_FWD_W  = 2'b01;
  localparam logic [1:0] C_FWD_M  = 2'b10;

  function automatic logic reg_match(input logic [REG_W-1:0] a,
                                     input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  logic [MD_W-1:0]  r_md_cnt;
  logic [RUN_W-1:0] r_run;
  logic             r_hang;
  logic [CNT_W-1:0] r_perf [3];

  logic w_rs_d_e, w_rt_d_e, w_rs_d_m, w_rt_d_m;
  logic w_lwstall, w_brstall, w_mdstall, w_stall;
  logic [1:0] w_cause;

  assign w_rs_d_e = reg_match(rs_d, writereg_e);
  assign w_rt_d_e = reg_match(rt_d, writereg_e);
  assign w_rs_d_m = reg_match(rs_d, writereg_m);
  assign w_rt_d_m = reg_match(rt_d, writereg_m);

  always_comb begin
    forward_ae = C_FWD_RF;
    if (regwrite_m && reg_match(rs_e, writereg_m))
      forward_ae = C_FWD_M;
    else if (regwrite_w && reg_match(rs_e, writereg_w))
      forward_ae = C_FWD_W;
  end

  always_comb begin
    forward_be = C_FWD_RF;
    if (regwrite_m && reg_match(rt_e, writereg_m))
      forward_be = C_FWD_M;
    else if (regwrite_w && reg_match(rt_e, writereg_w))
      forward_be = C_FWD_W;
  end

  assign forward_ad = w_rs_d_m && regwrite_m && branch_d;
  assign forward_bd = w_rt_d_m && regwrite_m && branch_d;

  assign w_lwstall = memtoreg_e && (w_rs_d_e || w_rt_d_e);
  assign w_brstall = branch_d &&
                     ((regwrite_e && (w_rs_d_e || w_rt_d_e)) ||
                      (memtoreg_m && (w_rs_d_m || w_rt_d_m)));
  // A mult issuing this very cycle must also hold a following mfhi/mflo.
  assign w_mdstall = mfhilo_d && (md_busy || md_start_e);
  assign w_stall   = w_lwstall || w_brstall || w_mdstall;

  always_comb begin
    w_cause = C_CAUSE_NONE;
    if (w_lwstall)
      w_cause = C_CAUSE_LOAD;
    else if (w_brstall)
      w_cause = C_CAUSE_BR;
    else if (w_mdstall)
      w_cause = C_CAUSE_MD;
  end

  assign stall_f     = w_stall;
  assign stall_d     = w_stall;
  assign flush_e     = w_stall;
  assign flush_d     = pcsrc_d && !w_stall;
  assign stall_cause = w_cause;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_md_cnt <= '0;
    else if (md_start_e)
      r_md_cnt <= C_MD_LOAD;
    else if (r_md_cnt != '0)
      r_md_cnt <= r_md_cnt - 1'b1;
  end

  assign md_busy = (r_md_cnt != '0);

  // Index k counts stall cycles whose reported cause is k+1.
  for (genvar k = 0; k < 3; k++) begin : g_perf
    localparam logic [1:0] C_SEL = 2'(k + 1);
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        r_perf[k] <= '0;
      else if (cnt_clr)
        r_perf[k] <= '0;
      else if ((w_cause == C_SEL) && (r_perf[k] != C_CNT_MAX))
        r_perf[k] <= r_perf[k] + 1'b1;
    end
  end

  assign lw_cnt = r_perf[0];
  assign br_cnt = r_perf[1];
  assign md_cnt = r_perf[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_run <= '0;
    else if (!w_stall)
      r_run <= '0;
    else if (r_run != C_RUN_MAX)
      r_run <= r_run + 1'b1;
  end

  // Error sets on the edge that closes the WD_MAX-th consecutive stall cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_hang <= 1'b0;
    else if (w_stall && (r_run >= C_RUN_LAST))
      r_hang <= 1'b1;
  end

  assign hang_err = r_hang;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_sb.sv
`default_nettype none
// Bench for hazard_unit_sb: vector table, corner sequences and random stimulus vs. a model.
module tb_hazard_unit_sb;

  localparam int REG_W  = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 16;
  localparam int WD_MAX = 8;
  localparam int CMAX   = 65535;
  localparam int CMAX2  = 3;

  typedef struct packed {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic rw_e, rw_m, rw_w, mtr_e, mtr_m, br, pc, mds, mfh, clr;
  } in_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic fad, fbd, stall, flush_d;
    logic [1:0] cause;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
  logic regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m;
  logic branch_d, pcsrc_d, md_start_e, mfhilo_d, cnt_clr;
  logic [1:0] forward_ae, forward_be, stall_cause;
  logic forward_ad, forward_bd, stall_f, stall_d, flush_d, flush_e, md_busy, hang_err;
  logic [CNT_W-1:0] lw_cnt, br_cnt, md_cnt;

  logic [1:0] s_fa, s_fb, s_cause;
  logic s_fad, s_fbd, s_stall_f, s_stall_d, s_flush_d, s_flush_e, s_busy, s_hang;
  logic [1:0] s_lw, s_br, s_md;

  always #5 clk = ~clk;

  hazard_unit_sb #(.REG_W(REG_W), .MD_LAT(MD_LAT), .CNT_W(CNT_W), .WD_MAX(WD_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m), .branch_d(branch_d),
    .pcsrc_d(pcsrc_d), .md_start_e(md_start_e), .mfhilo_d(mfhilo_d), .cnt_clr(cnt_clr),
    .forward_ae(forward_ae), .forward_be(forward_be), .forward_ad(forward_ad),
    .forward_bd(forward_bd), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .flush_e(flush_e), .md_busy(md_busy), .stall_cause(stall_cause),
    .lw_cnt(lw_cnt), .br_cnt(br_cnt), .md_cnt(md_cnt), .hang_err(hang_err));

  hazard_unit_sb #(.REG_W(REG_W), .MD_LAT(MD_LAT), .CNT_W(2), .WD_MAX(WD_MAX)) dut_sat (
    .clk(clk), .reset_n(reset_n), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m), .branch_d(branch_d),
    .pcsrc_d(pcsrc_d), .md_start_e(md_start_e), .mfhilo_d(mfhilo_d), .cnt_clr(cnt_clr),
    .forward_ae(s_fa), .forward_be(s_fb), .forward_ad(s_fad),
    .forward_bd(s_fbd), .stall_f(s_stall_f), .stall_d(s_stall_d), .flush_d(s_flush_d),
    .flush_e(s_flush_e), .md_busy(s_busy), .stall_cause(s_cause),
    .lw_cnt(s_lw), .br_cnt(s_br), .md_cnt(s_md), .hang_err(s_hang));

  int n_vec  = 0;
  int n_fail = 0;

  // Reference state: cycles of mult/div left, stall run length, counters per cause.
  int   md_rem, run;
  bit   hang;
  int   cnt  [3];
  int   cnt2 [3];
  in_t  cur_in;
  out_t cur_exp;
  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic bit mt(input logic [4:0] x, input logic [4:0] y);
    return (x != 0) && (x == y);
  endfunction

  function automatic out_t ref_out(input in_t v, input bit busy);
    out_t o;
    bit lw, bs, ms;
    o = '0;
    if (mt(v.rs_e, v.wr_m) && v.rw_m) o.fa = 2'b10;
    else if (mt(v.rs_e, v.wr_w) && v.rw_w) o.fa = 2'b01;
    if (mt(v.rt_e, v.wr_m) && v.rw_m) o.fb = 2'b10;
    else if (mt(v.rt_e, v.wr_w) && v.rw_w) o.fb = 2'b01;
    o.fad = mt(v.rs_d, v.wr_m) && v.rw_m && v.br;
    o.fbd = mt(v.rt_d, v.wr_m) && v.rw_m && v.br;
    lw = v.mtr_e && (mt(v.rs_d, v.wr_e) || mt(v.rt_d, v.wr_e));
    bs = v.br && ((v.rw_e && (mt(v.rs_d, v.wr_e) || mt(v.rt_d, v.wr_e))) ||
                  (v.mtr_m && (mt(v.rs_d, v.wr_m) || mt(v.rt_d, v.wr_m))));
    ms = v.mfh && (busy || v.mds);
    o.stall   = lw || bs || ms;
    o.flush_d = v.pc && !o.stall;
    o.cause   = lw ? 2'd1 : bs ? 2'd2 : ms ? 2'd3 : 2'd0;
    return o;
  endfunction

  task automatic model_reset();
    md_rem = 0; run = 0; hang = 0;
    for (int k = 0; k < 3; k++) begin cnt[k] = 0; cnt2[k] = 0; end
  endtask

  task automatic drive(input in_t v);
    rs_d = v.rs_d; rt_d = v.rt_d; rs_e = v.rs_e; rt_e = v.rt_e;
    writereg_e = v.wr_e; writereg_m = v.wr_m; writereg_w = v.wr_w;
    regwrite_e = v.rw_e; regwrite_m = v.rw_m; regwrite_w = v.rw_w;
    memtoreg_e = v.mtr_e; memtoreg_m = v.mtr_m; branch_d = v.br; pcsrc_d = v.pc;
    md_start_e = v.mds; mfhilo_d = v.mfh; cnt_clr = v.clr;
  endtask

  task automatic check_state();
    chk("md_busy", md_busy, md_rem > 0);
    chk("lw_cnt", lw_cnt, cnt[0]);
    chk("br_cnt", br_cnt, cnt[1]);
    chk("md_cnt", md_cnt, cnt[2]);
    chk("hang_err", hang_err, hang);
    chk("sat_lw_cnt", s_lw, cnt2[0]);
    chk("sat_br_cnt", s_br, cnt2[1]);
    chk("sat_md_cnt", s_md, cnt2[2]);
    chk("sat_hang", s_hang, hang);
  endtask

  task automatic apply(input in_t v);
    @(negedge clk);
    drive(v);
    #1;
    cur_in  = v;
    cur_exp = ref_out(v, md_rem > 0);
    chk("forward_ae", forward_ae, cur_exp.fa);
    chk("forward_be", forward_be, cur_exp.fb);
    chk("forward_ad", forward_ad, cur_exp.fad);
    chk("forward_bd", forward_bd, cur_exp.fbd);
    chk("stall_f", stall_f, cur_exp.stall);
    chk("stall_d", stall_d, cur_exp.stall);
    chk("flush_e", flush_e, cur_exp.stall);
    chk("flush_d", flush_d, cur_exp.flush_d);
    chk("stall_cause", stall_cause, cur_exp.cause);
    chk("sat_stall_f", s_stall_f, cur_exp.stall);
    check_state();
  endtask

  task automatic advance();
    @(posedge clk);
    if (cur_in.clr) begin
      for (int k = 0; k < 3; k++) begin cnt[k] = 0; cnt2[k] = 0; end
    end else if (cur_exp.stall) begin
      int idx;
      idx = int'(cur_exp.cause) - 1;
      if (cnt[idx] < CMAX) cnt[idx]++;
      if (cnt2[idx] < CMAX2) cnt2[idx]++;
    end
    if (cur_in.mds) md_rem = MD_LAT;
    else if (md_rem > 0) md_rem--;
    if (cur_exp.stall) begin
      if (run < WD_MAX) run++;
      if (run == WD_MAX) hang = 1;
    end else begin
      run = 0;
    end
  endtask

  task automatic step(input in_t v);
    apply(v);
    advance();
  endtask

  in_t v_idle, v_lw, v_clr, v_mul, v_mfh, v_r;
  int  nst;

  initial begin
    v_idle = '0;
    v_clr  = '{clr:1'b1, default:'0};
    v_lw   = '{rs_d:5'd8, wr_e:5'd8, rw_e:1'b1, mtr_e:1'b1, default:'0};
    v_mul  = '{mds:1'b1, mfh:1'b1, default:'0};
    v_mfh  = '{mfh:1'b1, default:'0};

    tbl[0]  = '{i:'0, o:'0};
    tbl[1]  = '{i:v_lw, o:'{stall:1'b1, cause:2'b01, default:'0}};
    tbl[2]  = '{i:'{rs_e:5'd8, wr_m:5'd8, rw_m:1'b1, default:'0}, o:'{fa:2'b10, default:'0}};
    tbl[3]  = '{i:'{br:1'b1, rs_d:5'd9, wr_e:5'd9, rw_e:1'b1, default:'0},
                o:'{stall:1'b1, cause:2'b10, default:'0}};
    tbl[4]  = '{i:'{br:1'b1, rs_d:5'd9, wr_m:5'd9, rw_m:1'b1, default:'0},
                o:'{fad:1'b1, default:'0}};
    tbl[5]  = '{i:'{br:1'b1, pc:1'b1, rs_d:5'd9, wr_m:5'd9, rw_m:1'b1, default:'0},
                o:'{fad:1'b1, flush_d:1'b1, default:'0}};
    tbl[6]  = '{i:'{br:1'b1, pc:1'b1, rs_d:5'd9, wr_e:5'd9, rw_e:1'b1, default:'0},
                o:'{stall:1'b1, cause:2'b10, default:'0}};
    tbl[7]  = '{i:'{rw_m:1'b1, rw_w:1'b1, default:'0}, o:'0};
    tbl[8]  = '{i:'{rs_e:5'd5, rt_e:5'd5, wr_m:5'd5, wr_w:5'd5, rw_m:1'b1, rw_w:1'b1, default:'0},
                o:'{fa:2'b10, fb:2'b10, default:'0}};
    tbl[9]  = '{i:'{rt_e:5'd7, wr_w:5'd7, rw_w:1'b1, default:'0}, o:'{fb:2'b01, default:'0}};
    tbl[10] = '{i:'{rs_e:5'd8, wr_m:5'd8, wr_w:5'd8, rw_w:1'b1, default:'0},
                o:'{fa:2'b01, default:'0}};
    tbl[11] = '{i:'{br:1'b1, rt_d:5'd3, wr_m:5'd3, rw_m:1'b1, mtr_m:1'b1, default:'0},
                o:'{fbd:1'b1, stall:1'b1, cause:2'b10, default:'0}};
    tbl[12] = '{i:'{br:1'b1, rs_d:5'd4, wr_e:5'd4, rw_e:1'b1, mtr_e:1'b1, default:'0},
                o:'{stall:1'b1, cause:2'b01, default:'0}};
    tbl[13] = '{i:v_mfh, o:'0};
    tbl[14] = '{i:v_mul, o:'{stall:1'b1, cause:2'b11, default:'0}};

    // Reset state
    reset_n = 1'b0;
    drive(v_idle);
    model_reset();
    #2;
    chk("rst_md_busy", md_busy, 0);
    chk("rst_lw_cnt", lw_cnt, 0);
    chk("rst_hang", hang_err, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Vector table
    for (int k = 0; k < 15; k++) begin
      apply(tbl[k].i);
      chk($sformatf("tbl%0d_fa", k), forward_ae, tbl[k].o.fa);
      chk($sformatf("tbl%0d_fb", k), forward_be, tbl[k].o.fb);
      chk($sformatf("tbl%0d_fad", k), forward_ad, tbl[k].o.fad);
      chk($sformatf("tbl%0d_fbd", k), forward_bd, tbl[k].o.fbd);
      chk($sformatf("tbl%0d_stall", k), stall_f, tbl[k].o.stall);
      chk($sformatf("tbl%0d_flush_d", k), flush_d, tbl[k].o.flush_d);
      chk($sformatf("tbl%0d_cause", k), stall_cause, tbl[k].o.cause);
      advance();
    end
    chk("tbl_lw_cnt", lw_cnt, 2);
    chk("tbl_br_cnt", br_cnt, 3);

    // Mult then mfhi back-to-back: MD_LAT+1 stall cycles
    step(v_clr);
    for (int k = 0; k < 5; k++) step(v_idle);
    nst = 0;
    apply(v_mul); if (stall_f) nst++; advance();
    for (int k = 0; k < 6; k++) begin
      apply(v_mfh); if (stall_f) nst++; advance();
    end
    chk("mul_stall_cycles", nst, MD_LAT + 1);
    apply(v_idle);
    chk("mul_md_cnt", md_cnt, MD_LAT + 1);
    chk("mul_busy_done", md_busy, 0);
    advance();

    // Restart while busy at counter=2
    step('{mds:1'b1, default:'0});
    step(v_idle);
    step(v_idle);
    apply('{mds:1'b1, default:'0});
    chk("restart_busy", md_busy, 1);
    advance();
    for (int k = 0; k < 3; k++) step(v_idle);
    apply(v_idle);
    chk("restart_busy_late", md_busy, 1);
    advance();
    for (int k = 0; k < 4; k++) step(v_idle);

    // Watchdog and narrow-counter saturation
    step(v_clr);
    chk("wd_hang_pre", hang_err, 0);
    for (int k = 0; k < WD_MAX; k++) begin
      apply(v_lw);
      if (k == WD_MAX - 1) chk("wd_hang_before_last", hang_err, 0);
      advance();
    end
    apply(v_idle);
    chk("wd_hang_set", hang_err, 1);
    chk("wd_lw_cnt", lw_cnt, WD_MAX);
    chk("sat2_lw_cnt", s_lw, 3);
    advance();
    step(v_clr);
    apply(v_idle);
    chk("wd_hang_after_clr", hang_err, 1);
    chk("wd_cnt_cleared", lw_cnt, 0);
    advance();

    // Random stimulus against the model
    for (int n = 0; n < 400; n++) begin
      v_r = '0;
      v_r.rs_d  = 5'($urandom_range(0, 3));
      v_r.rt_d  = 5'($urandom_range(0, 3));
      v_r.rs_e  = 5'($urandom_range(0, 3));
      v_r.rt_e  = 5'($urandom_range(0, 3));
      v_r.wr_e  = 5'($urandom_range(0, 3));
      v_r.wr_m  = 5'($urandom_range(0, 3));
      v_r.wr_w  = 5'($urandom_range(0, 3));
      v_r.rw_e  = 1'($urandom_range(0, 1));
      v_r.rw_m  = 1'($urandom_range(0, 1));
      v_r.rw_w  = 1'($urandom_range(0, 1));
      v_r.mtr_e = ($urandom_range(0, 2) == 0);
      v_r.mtr_m = ($urandom_range(0, 2) == 0);
      v_r.br    = 1'($urandom_range(0, 1));
      v_r.pc    = 1'($urandom_range(0, 1));
      v_r.mds   = ($urandom_range(0, 9) == 0);
      v_r.mfh   = ($urandom_range(0, 2) == 0);
      v_r.clr   = ($urandom_range(0, 29) == 0);
      step(v_r);
    end

    // Asynchronous reset mid-mult (counter=3)
    step('{mds:1'b1, default:'0});
    step(v_idle);
    apply(v_idle);
    chk("arst_busy_before", md_busy, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_md_busy", md_busy, 0);
    chk("arst_lw_cnt", lw_cnt, 0);
    chk("arst_br_cnt", br_cnt, 0);
    chk("arst_md_cnt", md_cnt, 0);
    chk("arst_hang", hang_err, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) step(v_lw);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
